// File: rtl/pool1_pkg.sv
// pool1_pkg -- shared constants and types for the first 2x2 binary max-pool layer.
//   CH          : channel count (one bit per channel)
//   WIDTH_DEF   : default conv1 output columns per row (even)
//   HEIGHT_DEF  : default conv1 output rows per frame (even)
//   POOL_W/H    : pooled frame dimensions at the default size
//   row_state_t : row phase FSM (even rows store pairs, odd rows emit)
package pool1_pkg;

    localparam int CH         = 8;
    localparam int WIDTH_DEF  = 26;
    localparam int HEIGHT_DEF = 26;
    localparam int POOL_W     = WIDTH_DEF / 2;
    localparam int POOL_H     = HEIGHT_DEF / 2;

    typedef enum logic {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } row_state_t;

endpackage

// File: rtl/pool1_line_buf.sv
// pool1_line_buf -- one-row buffer of horizontally pooled pairs.
//   clk    : clock, writes on rising edge
//   we     : write enable
//   waddr  : write entry (pair index, col>>1)
//   wdata  : CH-bit pair written from an even row
//   raddr  : read entry, asynchronous
//   rdata  : CH-bit pair stored by the preceding even row
// Contents are not reset: every entry is written in an even row before the
// odd row that reads it.
module pool1_line_buf #(
    parameter int DEPTH = pool1_pkg::POOL_W,
    parameter int CH    = pool1_pkg::CH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [CH-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [CH-1:0] rdata
);

    logic [CH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pool_layer_1.sv
// pool_layer_1 -- 2x2 binary max-pool (bitwise OR) over a streamed conv1 frame.
//   clk              : clock
//   rst              : asynchronous active-high reset
//   conv1_in         : one bit per channel, bit k = channel k+1
//   valid_in         : conv1_in carries a sample this cycle
//   pool1_out        : pooled bits, held between pulses
//   valid_out_pool1  : one-cycle pulse per pooled pixel
//   frame_done_pool1 : pulses together with the last pooled pixel of a frame
//   row_state        : debug view of the row phase FSM
// Handshake: valid-only. A sample is accepted on every rising edge with
// valid_in=1; there is no ready, the block never stalls its producer, and
// its consumer must take every valid_out_pool1 pulse.
module pool_layer_1
    import pool1_pkg::*;
#(
    parameter int WIDTH  = pool1_pkg::WIDTH_DEF,
    parameter int HEIGHT = pool1_pkg::HEIGHT_DEF,
    parameter int CH     = pool1_pkg::CH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] conv1_in,
    input  logic          valid_in,
    output logic [CH-1:0] pool1_out,
    output logic          valid_out_pool1,
    output logic          frame_done_pool1,
    output row_state_t    row_state
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int PW = WIDTH / 2;
    localparam int AW = $clog2(PW);

    row_state_t    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [CH-1:0] hold_q;
    logic [CH-1:0] pair;
    logic [CH-1:0] lb_rdata;
    logic [AW-1:0] lb_addr;
    logic          col_last;
    logic          row_last;
    logic          lb_we;
    logic          emit;

    assign col_last = (col_q == CW'(WIDTH - 1));
    assign row_last = (row_q == RW'(HEIGHT - 1));
    // Horizontal max of the current column pair; meaningful on odd columns.
    assign pair     = hold_q | conv1_in;
    assign lb_addr  = AW'(col_q >> 1);
    assign row_state = state_q;

    // Read and write share the address: an even row only writes and an odd
    // row only reads, so they never collide on the same row.
    pool1_line_buf #(
        .DEPTH (PW),
        .CH    (CH),
        .AW    (AW)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (pair),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        lb_we   = 1'b0;
        emit    = 1'b0;
        if (valid_in) begin
            if (col_last) begin
                col_d   = '0;
                row_d   = row_last ? '0 : row_q + 1'b1;
                state_d = (state_q == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (col_q[0]) begin
                case (state_q)
                    ROW_EVEN: lb_we = 1'b1;
                    ROW_ODD:  emit  = 1'b1;
                    default:  lb_we = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ROW_EVEN;
            col_q            <= '0;
            row_q            <= '0;
            hold_q           <= '0;
            pool1_out        <= '0;
            valid_out_pool1  <= 1'b0;
            frame_done_pool1 <= 1'b0;
        end else begin
            state_q          <= state_d;
            col_q            <= col_d;
            row_q            <= row_d;
            valid_out_pool1  <= emit;
            frame_done_pool1 <= emit && row_last && col_last;
            if (valid_in && !col_q[0]) begin
                hold_q <= conv1_in;
            end
            if (emit) begin
                pool1_out <= lb_rdata | pair;
            end
        end
    end

endmodule

// File: tb/tb_pool_layer_1.sv
module tb_pool_layer_1;
  import pool1_pkg::*;

  localparam int W   = 26;
  localparam int H   = 26;
  localparam int NCH = 8;
  localparam int PW  = W / 2;
  localparam int PH  = H / 2;
  localparam int NPIX = W * H;
  localparam int NOUT = PW * PH;

  logic           clk;
  logic           rst;
  logic [NCH-1:0] conv1_in;
  logic           valid_in;
  logic [NCH-1:0] pool1_out;
  logic           valid_out_pool1;
  logic           frame_done_pool1;
  row_state_t     row_state;

  pool_layer_1 #(.WIDTH(W), .HEIGHT(H), .CH(NCH)) dut (
    .clk              (clk),
    .rst              (rst),
    .conv1_in         (conv1_in),
    .valid_in         (valid_in),
    .pool1_out        (pool1_out),
    .valid_out_pool1  (valid_out_pool1),
    .frame_done_pool1 (frame_done_pool1),
    .row_state        (row_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [NCH-1:0] exp_q[$];
  bit             last_q[$];
  logic [NCH-1:0] pix [H][W];
  logic [NCH-1:0] last_val;
  int n_checks;
  int n_errors;
  int pulse_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: each pooled pixel is the OR of its 2x2 window, emitted in
  // raster order once the window's bottom-right sample has been accepted.
  // Only windows completed within the first n samples are queued.
  task automatic push_expected(input int n);
    for (int i = 0; i < PH; i++) begin
      for (int j = 0; j < PW; j++) begin
        if ((2*i + 1) * W + 2*j + 1 < n) begin
          exp_q.push_back(pix[2*i][2*j] | pix[2*i][2*j+1] |
                          pix[2*i+1][2*j] | pix[2*i+1][2*j+1]);
          last_q.push_back(i == PH - 1 && j == PW - 1);
        end
      end
    end
  endtask

  // compare process
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", {23'd0, valid_out_pool1, frame_done_pool1, pool1_out}, 32'd0);
      last_val = '0;
    end else if (valid_out_pool1) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        logic [NCH-1:0] e;
        bit             l;
        e = exp_q.pop_front();
        l = last_q.pop_front();
        chk("pool1_out", {24'd0, pool1_out}, {24'd0, e});
        chk("frame_done", {31'd0, frame_done_pool1}, {31'd0, l});
        last_val = e;
      end
    end else begin
      chk("hold_between", {24'd0, pool1_out}, {24'd0, last_val});
      chk("frame_done_idle", {31'd0, frame_done_pool1}, 32'd0);
    end
  end

  // driver tasks (called #1 after a rising edge)
  task automatic drive_sample(input logic [NCH-1:0] d, input bit gaps);
    if (gaps && $urandom_range(0, 1) == 1) @(posedge clk);
    if (gaps) #1;
    conv1_in = d;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    conv1_in = NCH'($urandom);
  endtask

  task automatic drive_range(input int lo, input int hi, input bit gaps);
    for (int k = lo; k < hi; k++) drive_sample(pix[k / W][k % W], gaps);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
    @(posedge clk);
    #1;
    chk(name, exp_q.size(), 32'd0);
    exp_q.delete();
    last_q.delete();
  endtask

  task automatic fill(input int mode, input int k);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (mode)
          0: pix[r][c] = '0;
          1: pix[r][c] = '1;
          2: pix[r][c] = ((r + c) % 2 == 1) ? NCH'(1 << k) : '0;
          default: pix[r][c] = NCH'($urandom);
        endcase
  endtask

  task automatic run_frame(input string name, input bit gaps);
    int start;
    start = pulse_cnt;
    push_expected(NPIX);
    drive_range(0, NPIX, gaps);
    drain({name, "_drain"});
    chk({name, "_count"}, pulse_cnt - start, NOUT);
  endtask

  initial begin
    int start;
    int nz;
    n_checks = 0;
    n_errors = 0;
    pulse_cnt = 0;
    last_val = '0;
    rst = 1'b1;
    valid_in = 1'b0;
    conv1_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_row_state", {31'd0, row_state}, {31'd0, ROW_EVEN});
    chk("reset_pool1_out", {24'd0, pool1_out}, 32'd0);

    // all-ones frame, continuous valid
    fill(1, 0);
    push_expected(NPIX);
    chk("model_ones_first", {24'd0, exp_q[0]}, 32'h0000_00FF);
    chk("model_ones_last_flag", {31'd0, last_q[NOUT-1]}, 32'd1);
    start = pulse_cnt;
    drive_range(0, W, 1'b0);
    chk("row_state_after_row0", {31'd0, row_state}, {31'd0, ROW_ODD});
    drive_range(W, NPIX, 1'b0);
    drain("ones_drain");
    chk("ones_count", pulse_cnt - start, NOUT);

    // single one on channel 3 at (5,8)
    fill(0, 0);
    pix[5][8] = 8'h04;
    push_expected(NPIX);
    chk("model_single_hit", {24'd0, exp_q[2*PW + 4]}, 32'h0000_0004);
    nz = 0;
    foreach (exp_q[i]) if (exp_q[i] != 0) nz++;
    chk("model_single_nonzero", nz, 32'd1);
    start = pulse_cnt;
    drive_range(0, NPIX, 1'b0);
    drain("single_drain");
    chk("single_count", pulse_cnt - start, NOUT);

    // random data with random valid gaps
    fill(3, 0);
    run_frame("random_gaps", 1'b1);

    // two frames back to back without reset: ones then zeros
    start = pulse_cnt;
    fill(1, 0);
    push_expected(NPIX);
    drive_range(0, NPIX, 1'b0);
    fill(0, 0);
    push_expected(NPIX);
    drive_range(0, NPIX, 1'b0);
    drain("two_frames_drain");
    chk("two_frames_count", pulse_cnt - start, 2 * NOUT);

    // reset after 300 samples, then a full frame
    fill(3, 0);
    push_expected(300);
    drive_range(0, 300, 1'b0);
    drain("partial_drain");
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_reset_row_state", {31'd0, row_state}, {31'd0, ROW_EVEN});
    fill(3, 0);
    run_frame("after_reset", 1'b1);

    // channel isolation with checkerboard
    for (int k = 0; k < NCH; k++) begin
      fill(2, k);
      push_expected(NPIX);
      chk("model_checker", {24'd0, exp_q[0]}, 32'(1 << k));
      start = pulse_cnt;
      drive_range(0, NPIX, 1'b0);
      drain("checker_drain");
      chk("checker_count", pulse_cnt - start, NOUT);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pool_layer_1.md
POOL_LAYER_1 -- requirements
Module: pool_layer_1

Interface
REQ-001 SHALL have parameter WIDTH, default 26, meaning conv1 output columns per row (even).
REQ-002 SHALL have parameter HEIGHT, default 26, meaning conv1 output rows per frame (even).
REQ-003 SHALL have parameter CH, default 8, meaning channel count.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 conv1_in  input  CH  one binary bit per channel from conv layer 1; bit k = channel k+1.
REQ-007 valid_in  input  1  conv1_in valid this cycle (driven by valid_out_conv1).
REQ-008 pool1_out  output  CH  2x2 max-pooled bit per channel.
REQ-009 valid_out_pool1  output  1  pool1_out valid this cycle, single-cycle pulse per pooled pixel.
REQ-010 frame_done_pool1  output  1  one-cycle pulse with the last pooled pixel of a frame.

Function
REQ-011 SHALL count accepted samples only (valid_in=1) with col counter 0..WIDTH-1 and row counter 0..HEIGHT-1, raster order; cycles with valid_in=0 SHALL change no state except clearing the output pulses.
REQ-012 col SHALL wrap WIDTH-1 -> 0 with row+1; row SHALL wrap HEIGHT-1 -> 0 at col wrap (next frame starts without reset).
REQ-013 Binary max SHALL be bitwise OR per channel.
REQ-014 Even col: SHALL latch conv1_in into hold register.
REQ-015 Odd col: pair = hold | conv1_in.
REQ-016 Even row, odd col: SHALL write pair into line buffer entry col>>1 (WIDTH/2 entries x CH bits); no output.
REQ-017 Odd row, odd col: SHALL register pool1_out = linebuf[col>>1] | pair and assert valid_out_pool1 on the next cycle (latency 1 cycle from accepting the 4th window sample).
REQ-018 pool1_out SHALL hold its value between pulses; valid_out_pool1 SHALL be 0 otherwise.
REQ-019 frame_done_pool1 SHALL pulse in the same cycle as the valid_out_pool1 for window (HEIGHT/2-1, WIDTH/2-1).
REQ-020 Output count SHALL be exactly (WIDTH/2)*(HEIGHT/2) pulses per frame (169 at defaults), regardless of valid_in gaps.
REQ-021 Back-to-back valid_in on every cycle SHALL be sustained with no stall; block has no backpressure.
REQ-022 Line-buffer read and write in the same cycle never target conflicting rows; read of entry in odd row SHALL return value written in the preceding even row.
REQ-023 Row phase SHALL be tracked by a 2-state FSM: ROW_EVEN (store) -> ROW_ODD (emit) on col wrap; ROW_ODD -> ROW_EVEN on col wrap.

Reset
REQ-024 rst=1 SHALL immediately force col=0, row=0, FSM=ROW_EVEN, hold=0, pool1_out=0, valid_out_pool1=0, frame_done_pool1=0.
REQ-025 Line buffer contents need not be reset; every entry is written before read.
REQ-026 Reset mid-frame SHALL discard the partial frame; first valid_in after release is pixel (0,0).

Structure
REQ-027 Shared package pool1_pkg SHALL hold CH, default WIDTH/HEIGHT, derived POOL_W=WIDTH/2, POOL_H=HEIGHT/2, and FSM state typedef.
REQ-028 One sub-module pool1_line_buf (POOL_W x CH register array, one write port, one async read port) SHALL be instantiated.
REQ-029 Counter widths SHALL be clog2 of WIDTH and HEIGHT.

Verification
REQ-030 All-ones frame, valid_in continuous 676 cycles -> 169 pulses, pool1_out=8'hFF each, frame_done at 169th.
REQ-031 Single 1 on channel 3 at (row 5, col 8) only -> pooled (2,4) pool1_out=8'h04, all other 168 outputs 8'h00.
REQ-032 Random valid_in gaps (50% duty) with random data -> outputs match reference OR-pool model, count 169.
REQ-033 Two frames back-to-back without reset -> 338 pulses, second frame independent of first (first frame all ones, second all zeros -> second frame outputs 8'h00).
REQ-034 rst asserted after 300 samples, released, full frame sent -> all outputs 0 during reset, then 169 correct pulses.
REQ-035 Channel isolation: channel k driven with checkerboard, others 0 -> only bit k set in every output (8'h01<<k).
